// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared states and coin constants for multi_vending_machine
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } vm_state_e;

    localparam int COIN1_VAL     = 1;
    localparam int COIN2_VAL     = 2;
    localparam int DEFAULT_PRICE = 4;

endpackage

// File: rtl/multi_vending_machine_if.sv
// rtl/multi_vending_machine_if.sv - customer/operator and status signals of the vending machine
interface multi_vending_machine_if #(
    parameter int NUM_ITEMS = 4,
    parameter int STOCK_W   = 4,
    parameter int CREDIT_W  = 6
);
    localparam int SEL_W = $clog2(NUM_ITEMS);

    logic                           coin1;
    logic                           coin2;
    logic [SEL_W-1:0]               item_sel;
    logic                           vend_req;
    logic                           load;
    logic [STOCK_W-1:0]             load_qty;
    logic                           cancel;
    logic [NUM_ITEMS-1:0]           deliver;
    logic [CREDIT_W-1:0]            change;
    logic                           change_valid;
    logic [CREDIT_W-1:0]            credit;
    logic [NUM_ITEMS*STOCK_W-1:0]   stock;
    logic [NUM_ITEMS-1:0]           sold_out;
    logic                           vend_err;
    logic                           busy;

    modport slave (
        input  coin1, coin2, item_sel, vend_req, load, load_qty, cancel,
        output deliver, change, change_valid, credit, stock, sold_out, vend_err, busy
    );

    modport master (
        output coin1, coin2, item_sel, vend_req, load, load_qty, cancel,
        input  deliver, change, change_valid, credit, stock, sold_out, vend_err, busy
    );

endinterface

// File: rtl/vm_stock_bank.sv
// rtl/vm_stock_bank.sv - per-slot stock counters with load and saturating decrement
module vm_stock_bank #(
    parameter int NUM_ITEMS = 4,
    parameter int STOCK_W   = 4,
    parameter int SEL_W     = $clog2(NUM_ITEMS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [SEL_W-1:0]             load_sel_i,
    input  logic [STOCK_W-1:0]           load_qty_i,
    input  logic                         dec_i,
    input  logic [SEL_W-1:0]             dec_sel_i,
    output logic [NUM_ITEMS*STOCK_W-1:0] stock_o,
    output logic [NUM_ITEMS-1:0]         sold_out_o
);

    logic [STOCK_W-1:0] cnt_q [NUM_ITEMS];
    logic [STOCK_W-1:0] cnt_d [NUM_ITEMS];

    // Next count per slot: load wins, decrement never wraps below zero
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load_i && (load_sel_i == SEL_W'(i))) begin
                cnt_d[i] = load_qty_i;
            end else if (dec_i && (dec_sel_i == SEL_W'(i)) && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - STOCK_W'(1);
            end
        end
    end

    // Counter registers, emptied on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counts (slot 0 in LSBs) and flag empty slots
    always_comb begin
        stock_o    = '0;
        sold_out_o = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_o[i*STOCK_W +: STOCK_W] = cnt_q[i];
            sold_out_o[i]                 = (cnt_q[i] == '0);
        end
    end

endmodule

// File: rtl/multi_vending_machine.sv
// rtl/multi_vending_machine.sv - multi-slot vending FSM; optional refund on cancel via VM_REFUND_EN
module multi_vending_machine
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int STOCK_W   = 4,
    parameter int CREDIT_W  = 6,
    parameter int PRICE     = DEFAULT_PRICE
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_vending_machine_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_ITEMS);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

`ifdef VM_REFUND_EN
    localparam bit REFUND_EN = 1'b1;
`else
    localparam bit REFUND_EN = 1'b0;
`endif

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    slot_q, slot_d;
    logic                vend_err_q, vend_err_d;
    logic [CREDIT_W:0]   coin_val, coin_sum;
    logic                coin_ok;
    logic                sel_valid;
    logic                dec_en, load_en;
    logic [NUM_ITEMS-1:0] sold_out;
    logic [NUM_ITEMS*STOCK_W-1:0] stock;

    // Coin value this cycle; the extra sum bit exposes an overflowing coin so it can be dropped
    always_comb begin
        coin_val = '0;
        if (bus.coin1) coin_val = coin_val + (CREDIT_W+1)'(COIN1_VAL);
        if (bus.coin2) coin_val = coin_val + (CREDIT_W+1)'(COIN2_VAL);
        coin_sum  = {1'b0, credit_q} + coin_val;
        coin_ok   = (bus.coin1 | bus.coin2) && !coin_sum[CREDIT_W];
        sel_valid = (32'(bus.item_sel) < NUM_ITEMS);
    end

    // Next-state logic; vend decisions use the registered credit only
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        slot_d     = slot_q;
        vend_err_d = 1'b0;
        dec_en     = 1'b0;
        load_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                credit_d = '0;
                if (coin_ok) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = ST_COLLECT;
                end
                if (bus.vend_req) vend_err_d = 1'b1;
                if (bus.load)     load_en    = 1'b1;
            end
            ST_COLLECT: begin
                if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
                if (bus.vend_req) begin
                    if ((credit_q >= PRICE_C) && sel_valid && !sold_out[bus.item_sel]) begin
                        state_d = ST_VEND;
                        slot_d  = bus.item_sel;
                    end else begin
                        vend_err_d = 1'b1;
                    end
                end else if (REFUND_EN && bus.cancel) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_VEND: begin
                dec_en   = 1'b1;
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q != PRICE_C) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                credit_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset silently drops any credit in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            slot_q     <= '0;
            vend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            slot_q     <= slot_d;
            vend_err_q <= vend_err_d;
        end
    end

    vm_stock_bank #(
        .NUM_ITEMS (NUM_ITEMS),
        .STOCK_W   (STOCK_W),
        .SEL_W     (SEL_W)
    ) u_stock (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_en),
        .load_sel_i (bus.item_sel),
        .load_qty_i (bus.load_qty),
        .dec_i      (dec_en),
        .dec_sel_i  (slot_q),
        .stock_o    (stock),
        .sold_out_o (sold_out)
    );

    // Outputs decoded from registered state
    always_comb begin
        bus.deliver      = (state_q == ST_VEND) ? (NUM_ITEMS'(1) << slot_q) : '0;
        bus.change       = (state_q == ST_CHANGE) ? credit_q : '0;
        bus.change_valid = (state_q == ST_CHANGE);
        bus.credit       = credit_q;
        bus.stock        = stock;
        bus.sold_out     = sold_out;
        bus.vend_err     = vend_err_q;
        bus.busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);
    end

endmodule

// File: tb/tb_multi_vending_machine.sv
// tb/tb_multi_vending_machine.sv - scoreboard bench for multi_vending_machine
module tb_multi_vending_machine;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int CW = 6;

    localparam int K_DEL = 0;
    localparam int K_CHG = 1;
    localparam int K_ERR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    multi_vending_machine_if #(.NUM_ITEMS(N), .STOCK_W(SW), .CREDIT_W(CW)) vif ();

    multi_vending_machine #(
        .NUM_ITEMS (N),
        .STOCK_W   (SW),
        .CREDIT_W  (CW),
        .PRICE     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct {
        int kind;
        int value;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input int value);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d value %0d, expected none", kind, value);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value != value) begin
                n_fail++;
                $display("FAIL event: got kind %0d value %0d expected kind %0d value %0d",
                         kind, value, e.kind, e.value);
            end
        end
    endtask

    // Monitor: every output strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (vif.deliver != '0) observe(K_DEL, int'(vif.deliver));
        if (vif.change_valid)  observe(K_CHG, int'(vif.change));
        if (vif.vend_err)      observe(K_ERR, 0);
    end

    task automatic push(input int kind, input int value);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        vif.coin1    = 1'b0;
        vif.coin2    = 1'b0;
        vif.vend_req = 1'b0;
        vif.load     = 1'b0;
        vif.cancel   = 1'b0;
    endtask

    task automatic coins(input logic c1, input logic c2);
        vif.coin1 = c1;
        vif.coin2 = c2;
        tick();
        clr();
    endtask

    task automatic do_load(input int sel, input int qty);
        vif.item_sel = 2'(sel);
        vif.load_qty = 4'(qty);
        vif.load     = 1'b1;
        tick();
        clr();
    endtask

    task automatic vend(input int sel, input logic c1);
        vif.item_sel = 2'(sel);
        vif.vend_req = 1'b1;
        vif.coin1    = c1;
        tick();
        clr();
    endtask

    initial begin
        clr();
        vif.item_sel = '0;
        vif.load_qty = '0;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_credit", vif.credit, 0);
        chk("rst_stock", vif.stock, 0);
        chk("rst_sold_out", vif.sold_out, 4'hF);
        chk("rst_busy", vif.busy, 0);
        chk("rst_deliver", vif.deliver, 0);
        chk("rst_change_valid", vif.change_valid, 0);
        rst = 1'b1;
        tick();

        // vend_req in IDLE is rejected
        push(K_ERR, 0);
        vend(0, 1'b0);
        tick();
        chk("idle_err_credit", vif.credit, 0);

        // Exact-price purchase from slot 1
        do_load(1, 2);
        chk("load1_stock", vif.stock, 16'h0020);
        coins(1'b0, 1'b1);
        coins(1'b0, 1'b1);
        chk("exact_credit", vif.credit, 4);
        push(K_DEL, 4'b0010);
        vend(1, 1'b0);
        chk("vend_busy", vif.busy, 1);
        tick();
        chk("exact_after_credit", vif.credit, 0);
        chk("exact_after_stock", vif.stock, 16'h0010);
        chk("exact_after_busy", vif.busy, 0);

        // Overpay returns change
        do_load(0, 3);
        coins(1'b0, 1'b1);
        coins(1'b0, 1'b1);
        coins(1'b0, 1'b1);
        chk("over_credit", vif.credit, 6);
        push(K_DEL, 4'b0001);
        push(K_CHG, 2);
        vend(0, 1'b0);
        tick();
        tick();
        chk("over_after_credit", vif.credit, 0);
        chk("over_after_stock", vif.stock, 16'h0012);

        // Sold-out rejection, load ignored outside IDLE, coin with vend_req, coin during VEND
        coins(1'b0, 1'b1);
        coins(1'b0, 1'b1);
        push(K_ERR, 0);
        vend(2, 1'b0);
        chk("soldout_credit", vif.credit, 4);
        do_load(2, 5);
        chk("collect_load_ignored", vif.stock, 16'h0012);
        push(K_DEL, 4'b0001);
        push(K_CHG, 1);
        vend(0, 1'b1);
        coins(1'b0, 1'b1);
        tick();
        chk("mixed_after_credit", vif.credit, 0);
        chk("mixed_after_stock", vif.stock, 16'h0011);

        // Dual coins and credit ceiling
        do_load(3, 1);
        coins(1'b1, 1'b1);
        coins(1'b1, 1'b1);
        chk("dual_coin_credit", vif.credit, 6);
        for (int i = 0; i < 28; i++) coins(1'b0, 1'b1);
        chk("credit_62", vif.credit, 62);
        coins(1'b0, 1'b1);
        chk("overflow_discard", vif.credit, 62);
        coins(1'b1, 1'b0);
        chk("credit_63", vif.credit, 63);
        push(K_DEL, 4'b1000);
        push(K_CHG, 59);
        vend(3, 1'b0);
        tick();
        tick();
        chk("ceiling_after_credit", vif.credit, 0);
        chk("ceiling_sold_out", vif.sold_out, 4'b1100);

        // Cancel
        coins(1'b1, 1'b1);
        chk("cancel_credit_before", vif.credit, 3);
        vif.cancel = 1'b1;
`ifdef VM_REFUND_EN
        push(K_CHG, 3);
        tick();
        clr();
        chk("refund_busy", vif.busy, 1);
        tick();
        chk("refund_credit", vif.credit, 0);
        coins(1'b0, 1'b1);
        coins(1'b0, 1'b1);
`else
        tick();
        clr();
        chk("cancel_ignored_credit", vif.credit, 3);
        chk("cancel_ignored_busy", vif.busy, 0);
        coins(1'b1, 1'b0);
`endif
        chk("pre_reset_credit", vif.credit, 4);

        // Reset during VEND
        push(K_DEL, 4'b0001);
        vend(0, 1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_credit", vif.credit, 0);
        chk("midrst_stock", vif.stock, 0);
        chk("midrst_busy", vif.busy, 0);
        chk("midrst_change_valid", vif.change_valid, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
